// File: rtl/frame_downloader_if.sv
// Bundle of the frame downloader's control, PSRAM-read and line-buffer signals.
// No logic: wires only, so it adds no latency.
// The arbiter applies backpressure by holding read_ack; the line buffer applies none.
//
// master : the downloader (drives read_rq/read_addr, the lb_* write port and status)
// slave  : the environment (arbiter, PSRAM data path, consumer, control)
interface frame_downloader_if;
    logic        start;
    logic [20:0] base_addr;
    logic        row_req;
    logic        read_ack;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        read_rq;
    logic [20:0] read_addr;
    logic [9:0]  lb_addr;
    logic        lb_bank;
    logic [31:0] lb_data;
    logic        lb_wr_en;
    logic        row_ready;
    logic        download_done;
    logic        busy;

    modport master (
        input  start, base_addr, row_req, read_ack, read_data, read_data_valid,
        output read_rq, read_addr, lb_addr, lb_bank, lb_data, lb_wr_en,
               row_ready, download_done, busy
    );

    modport slave (
        output start, base_addr, row_req, read_ack, read_data, read_data_valid,
        input  read_rq, read_addr, lb_addr, lb_bank, lb_data, lb_wr_en,
               row_ready, download_done, busy
    );
endinterface

// File: rtl/frame_downloader.sv
// Reads a frame out of PSRAM row by row in bursts and fills a double-banked line buffer.
// Line-buffer write is registered (1 cycle after read_data_valid); status pulses decode from state.
// Stalls on read_ack (grant and its release) and paces rows on consumer row_req pulses.
//
// Ports: clk, reset_n (async, active low); bus (frame_downloader_if.master) carrying
//   start/base_addr, row_req, read_rq/read_addr/read_ack/read_data/read_data_valid,
//   lb_addr/lb_bank/lb_data/lb_wr_en, row_ready, download_done, busy.
// Optional: define FRAME_DOWNLOADER_TIMEOUT_EN to add a 16-bit grant/data watchdog
//   and a sticky 'error' output port.
module frame_downloader #(
    parameter int MEMORY_BURST = 32,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic clk,
    input  logic reset_n,
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
    output logic error,
`endif
    frame_downloader_if.master bus
);

    localparam int WORDS_PER_BURST = MEMORY_BURST / 4;
    localparam int ADDR_STEP       = MEMORY_BURST / 2;
    localparam int ROW_WORDS       = FRAME_WIDTH / 2;
    localparam int BURSTS_PER_ROW  = ROW_WORDS / WORDS_PER_BURST;

    localparam logic [4:0]  LAST_BEAT  = 5'(WORDS_PER_BURST - 1);
    localparam logic [9:0]  LAST_BURST = 10'(BURSTS_PER_ROW - 1);
    localparam logic [15:0] LAST_ROW   = 16'(FRAME_HEIGHT - 1);
    localparam logic [20:0] ADDR_INC   = 21'(ADDR_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ROW,
        S_REQ,
        S_DATA,
        S_BURST_END,
        S_ROW_END,
        S_FRAME_END
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [20:0] frame_addr;
    logic [15:0] row_cnt;
    logic [9:0]  burst_cnt;
    logic [4:0]  beat_cnt;
    logic [9:0]  word_cnt;
    logic        bank;
    logic        row_pend;
    logic        lb_wr_en_q;
    logic [9:0]  lb_addr_q;
    logic [31:0] lb_data_q;

    logic        beat_take;
    logic        last_beat;
    logic        timeout_hit;

    // Data is only accepted while the burst is owned; anything else on
    // read_data_valid (stray beats, beats past the burst length) falls through.
    assign beat_take = (state == S_DATA) && bus.read_data_valid;
    assign last_beat = beat_take && (beat_cnt == LAST_BEAT);

`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
    logic [15:0] wdog;
    logic        err_q;
    logic        in_burst;

    assign in_burst = (state == S_REQ) || (state == S_DATA);

    // Trips on the cycle the idle count would reach 0xFFFF, so a request that is
    // never granted spends exactly 65535 cycles in REQ before being abandoned.
    assign timeout_hit = in_burst && !bus.read_ack && !bus.read_data_valid &&
                         (wdog == 16'hFFFE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            if (!in_burst || bus.read_ack || bus.read_data_valid)
                wdog <= '0;
            else
                wdog <= wdog + 16'd1;

            if ((state == S_IDLE) && bus.start)
                err_q <= 1'b0;
            else if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (bus.start) state_nxt = S_WAIT_ROW;
            S_WAIT_ROW:  if (row_pend) state_nxt = S_REQ;
            S_REQ:       if (bus.read_ack) state_nxt = S_DATA;
            S_DATA:      if (last_beat) state_nxt = S_BURST_END;
            // The next request waits for the arbiter to release the previous
            // grant, so a lingering read_ack can never be mistaken for a new one.
            S_BURST_END: if (!bus.read_ack)
                             state_nxt = (burst_cnt == LAST_BURST) ? S_ROW_END : S_REQ;
            S_ROW_END:   state_nxt = (row_cnt == LAST_ROW) ? S_FRAME_END : S_WAIT_ROW;
            S_FRAME_END: state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (timeout_hit)
            state_nxt = S_FRAME_END;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_addr <= '0;
            row_cnt    <= '0;
            burst_cnt  <= '0;
            beat_cnt   <= '0;
            word_cnt   <= '0;
            bank       <= 1'b0;
            row_pend   <= 1'b0;
            lb_wr_en_q <= 1'b0;
            lb_addr_q  <= '0;
            lb_data_q  <= '0;
        end else begin
            lb_wr_en_q <= beat_take;
            if (beat_take) begin
                lb_addr_q <= word_cnt;
                lb_data_q <= bus.read_data;
                word_cnt  <= word_cnt + 10'd1;
            end

            if (state != S_DATA)
                beat_cnt <= '0;
            else if (beat_take)
                beat_cnt <= beat_cnt + 5'd1;

            // 21-bit add: the carry out of bit 20 is dropped, wrapping at 2^21.
            if (last_beat)
                frame_addr <= frame_addr + ADDR_INC;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        frame_addr <= bus.base_addr;
                        row_cnt    <= '0;
                        bank       <= 1'b0;
                    end
                end
                S_WAIT_ROW: begin
                    if (row_pend) begin
                        word_cnt  <= '0;
                        burst_cnt <= '0;
                    end
                end
                S_BURST_END: begin
                    if (!bus.read_ack && (burst_cnt != LAST_BURST))
                        burst_cnt <= burst_cnt + 10'd1;
                end
                S_ROW_END: begin
                    bank    <= ~bank;
                    row_cnt <= row_cnt + 16'd1;
                end
                default: ;
            endcase

            // One-deep request memory. A request landing in the same cycle that
            // WAIT_ROW consumes the flag keeps it set for the following row.
            if (state == S_IDLE)
                row_pend <= 1'b0;
            else if (bus.row_req)
                row_pend <= 1'b1;
            else if (state == S_WAIT_ROW)
                row_pend <= 1'b0;
        end
    end

    assign bus.read_rq       = (state == S_REQ) || (state == S_DATA);
    assign bus.read_addr     = frame_addr;
    assign bus.lb_addr       = lb_addr_q;
    assign bus.lb_bank       = bank;
    assign bus.lb_data       = lb_data_q;
    assign bus.lb_wr_en      = lb_wr_en_q;
    assign bus.row_ready     = (state == S_ROW_END);
    assign bus.download_done = (state == S_FRAME_END);
    // Low during the download_done pulse itself: busy covers start..done exclusive.
    assign bus.busy          = (state != S_IDLE) && (state != S_FRAME_END);

endmodule

// File: tb/tb_frame_downloader.sv
// Bench for frame_downloader: 32-pixel x 2-row frame, 32-byte bursts.
// Checks sampled on the falling edge; inputs driven on the falling edge.
// Arbiter/PSRAM model in tasks; line-buffer writes checked against a scoreboard queue.
module tb_frame_downloader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    frame_downloader_if bus ();
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
    logic error;
`endif

    frame_downloader #(
        .MEMORY_BURST(32),
        .FRAME_WIDTH (32),
        .FRAME_HEIGHT(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
        .error  (error),
`endif
        .bus    (bus)
    );

    typedef struct packed {
        logic        bank;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [20:0] base;
        int          hold;    // extra cycles read_ack stays high after the last word
        bit          queued;  // row_req pulses during row 0 instead of after it
        bit          stray;   // read_data_valid while waiting for a row request
        bit          extra;   // one valid word beyond the burst length
        logic [20:0] a0, a1, a2, a3;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   rr_cnt = 0;
    int   done_cnt = 0;
    wr_t  wr_q[$];
    logic rr_q[$];
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        if (bus.lb_wr_en) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL lb_write: unexpected write addr 0x%0h bank %0d, expected none",
                         bus.lb_addr, bus.lb_bank);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                checks--;
                chk("lb_write", {bus.lb_bank, bus.lb_addr, bus.lb_data}, e);
            end
        end
        if (bus.row_ready) begin
            rr_cnt++;
            checks++;
            if (rr_q.size() == 0) begin
                errors++;
                $display("FAIL row_ready: unexpected pulse, expected none");
            end else begin
                logic b;
                b = rr_q.pop_front();
                checks--;
                chk("row_ready_bank", bus.lb_bank, b);
            end
        end
        if (bus.download_done) begin
            done_cnt++;
            chk("busy_at_done", bus.busy, 0);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_rq(output int n);
        n = 0;
        while (!bus.read_rq && n < 64) begin
            cyc();
            n++;
        end
        chk("read_rq_seen", bus.read_rq, 1);
    endtask

    task automatic serve_burst(input logic [20:0] exp_addr, input logic bank, input int wbase,
                               input int hold, input bit extra, input bit req_pulse,
                               output int waited);
        logic [31:0] d;
        wait_rq(waited);
        chk("read_addr", bus.read_addr, exp_addr);
        bus.read_ack = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                bus.read_data_valid = 1'b0;
                cyc();
            end
            d = $urandom();
            wr_q.push_back({bank, 10'(wbase + i), d});
            bus.read_data       = d;
            bus.read_data_valid = 1'b1;
            bus.row_req         = req_pulse && (i == 1);
            cyc();
        end
        bus.row_req = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            chk("rq_low_after_burst", bus.read_rq, 0);
            bus.read_data       = $urandom();
            bus.read_data_valid = extra && (h == 0);
            bus.read_ack        = (h < hold);
            cyc();
        end
        bus.read_data_valid = 1'b0;
    endtask

    task automatic pulse_row_req();
        bus.row_req = 1'b1;
        cyc();
        bus.row_req = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int w;
        int rr0;
        int d0;
        rr0 = rr_cnt;
        d0  = done_cnt;
        bus.base_addr = v.base;
        bus.start     = 1'b1;
        cyc();
        bus.start     = 1'b0;
        bus.base_addr = ~v.base;
        chk("busy_after_start", bus.busy, 1);
        if (v.stray) begin
            bus.read_data       = 32'hDEAD_BEEF;
            bus.read_data_valid = 1'b1;
            cyc();
            chk("stray_no_write", bus.lb_wr_en, 0);
            cyc();
            chk("stray_no_write", bus.lb_wr_en, 0);
            bus.read_data_valid = 1'b0;
            cyc();
            chk("stray_no_write", bus.lb_wr_en, 0);
        end
        pulse_row_req();
        serve_burst(v.a0, 1'b0, 0, v.hold, v.extra, v.queued, w);
        rr_q.push_back(1'b0);
        serve_burst(v.a1, 1'b0, 8, v.hold, v.extra, v.queued, w);
        chk("row0_ready_count", rr_cnt - rr0, 1);
        if (!v.queued)
            pulse_row_req();
        serve_burst(v.a2, 1'b1, 0, v.hold, v.extra, 1'b0, w);
        if (v.queued)
            chk("queued_row_immediate", (w <= 3), 1);
        rr_q.push_back(1'b1);
        serve_burst(v.a3, 1'b1, 8, v.hold, v.extra, 1'b0, w);
        chk("row1_ready_count", rr_cnt - rr0, 2);
        cyc();
        chk("download_done_count", done_cnt - d0, 1);
        chk("busy_after_done", bus.busy, 0);
        repeat (4) cyc();
        chk("no_restart_after_done", bus.read_rq, 0);
        chk("writes_all_seen", wr_q.size(), 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int w;
        vecs[0] = '{21'h000100, 0, 1'b0, 1'b1, 1'b0,
                    21'h000100, 21'h000110, 21'h000120, 21'h000130};
        vecs[1] = '{21'h000400, 3, 1'b0, 1'b0, 1'b1,
                    21'h000400, 21'h000410, 21'h000420, 21'h000430};
        vecs[2] = '{21'h1FFFF0, 0, 1'b1, 1'b0, 1'b0,
                    21'h1FFFF0, 21'h000000, 21'h000010, 21'h000020};
        vecs[3] = '{21'h1FFFE0, 2, 1'b1, 1'b0, 1'b1,
                    21'h1FFFE0, 21'h1FFFF0, 21'h000000, 21'h000010};

        bus.start           = 1'b0;
        bus.base_addr       = '0;
        bus.row_req         = 1'b0;
        bus.read_ack        = 1'b0;
        bus.read_data       = '0;
        bus.read_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {bus.read_rq, bus.read_addr, bus.lb_addr, bus.lb_bank, bus.lb_wr_en,
                           bus.row_ready, bus.download_done, bus.busy}, 0);
        chk("reset_lb_data", bus.lb_data, 0);
        reset_n = 1'b1;
        cyc();
        chk("idle_busy", bus.busy, 0);

        // row_req in IDLE must not be remembered.
        pulse_row_req();
        for (int i = 0; i < 4; i++) begin
            bus.start = (i == 0);
            bus.base_addr = 21'h000100;
            cyc();
            bus.start = 1'b0;
        end
        chk("idle_row_req_ignored", bus.read_rq, 0);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();

        for (int i = 0; i < 4; i++)
            run_frame(vecs[i]);

        // Reset in the middle of a burst, after three words.
        bus.base_addr = 21'h000200;
        bus.start     = 1'b1;
        cyc();
        bus.start = 1'b0;
        pulse_row_req();
        wait_rq(w);
        chk("rst_read_addr", bus.read_addr, 21'h000200);
        bus.read_ack = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus.read_data = 32'hC0DE_0000 + 32'(i);
            wr_q.push_back({1'b0, 10'(i), 32'hC0DE_0000 + 32'(i)});
            bus.read_data_valid = 1'b1;
            cyc();
        end
        chk("pre_reset_wr_en", bus.lb_wr_en, 1);
        bus.read_data = 32'hBAD0_0003;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_read_rq", bus.read_rq, 0);
        chk("async_rst_wr_en", bus.lb_wr_en, 0);
        chk("async_rst_busy", bus.busy, 0);
        cyc();
        bus.read_ack        = 1'b0;
        bus.read_data_valid = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("post_reset_queue", wr_q.size(), 0);
        run_frame(vecs[1]);

`ifdef FRAME_DOWNLOADER_TIMEOUT_EN
        begin
            int n;
            int rq_cyc;
            n = 0;
            rq_cyc = 0;
            bus.base_addr = 21'h000100;
            bus.start = 1'b1;
            cyc();
            bus.start = 1'b0;
            pulse_row_req();
            while (!bus.download_done && n < 70000) begin
                cyc();
                if (bus.read_rq) rq_cyc++;
                n++;
            end
            chk("timeout_done", bus.download_done, 1);
            chk("timeout_rq_cycles", rq_cyc, 65535);
            chk("timeout_error", error, 1);
            cyc();
            chk("timeout_error_sticky", error, 1);
            bus.start = 1'b1;
            cyc();
            bus.start = 1'b0;
            chk("error_cleared_by_start", error, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
